// File: rtl/cp0_exception_ctrl.sv
// Commit-stage exception/interrupt sequencer: owns the CP0 write port and
// steps through BadVAddr, Cause, EPC, Status writes before redirecting fetch.
module cp0_exception_ctrl #(
    parameter int              WIDTH      = 32,
    parameter logic [WIDTH-1:0] EXC_VECTOR = 32'hBFC00380
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inst_valid,
    input  logic [WIDTH-1:0] inst_pc,
    input  logic             inst_bd,
    input  logic             exc_valid,
    input  logic [4:0]       exc_code,
    input  logic             exc_has_badv,
    input  logic [WIDTH-1:0] exc_badvaddr,
    input  logic             eret_valid,
    input  logic [7:0]       int_pending,
    input  logic [WIDTH-1:0] status_in,
    input  logic [WIDTH-1:0] epc_in,
    output logic             cp0_we,
    output logic [4:0]       cp0_waddr,
    output logic [WIDTH-1:0] cp0_wdata,
    output logic             flush,
    output logic             busy,
    output logic             redirect_valid,
    output logic [WIDTH-1:0] redirect_pc
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_W_BADV   = 3'd1;
    localparam logic [2:0] S_W_CAUSE  = 3'd2;
    localparam logic [2:0] S_W_EPC    = 3'd3;
    localparam logic [2:0] S_W_STATUS = 3'd4;
    localparam logic [2:0] S_E_STATUS = 3'd5;
    localparam logic [2:0] S_REDIRECT = 3'd6;

    function automatic logic [WIDTH-1:0] cause_word(input logic bd, input logic [7:0] ip,
                                                    input logic [4:0] code);
        logic [31:0] w;
        w = {bd, 15'b0, ip, 1'b0, code, 2'b00};
        return WIDTH'(w);
    endfunction

    function automatic logic [WIDTH-1:0] with_exl(input logic [WIDTH-1:0] stat, input logic exl);
        logic [WIDTH-1:0] r;
        r    = stat;
        r[1] = exl;
        return r;
    endfunction

    logic [2:0]       state_r, state_s;
    logic [4:0]       code_r, code_s;
    logic             bd_r, bd_s;
    logic [WIDTH-1:0] epc_r, epc_s;
    logic [WIDTH-1:0] badv_r, badv_s;
    logic [7:0]       ip_r, ip_s;
    logic [WIDTH-1:0] stat_r, stat_s;
    logic [WIDTH-1:0] target_r, target_s;
    logic             has_badv_r, has_badv_s;
    logic             eret_r, eret_s;

    logic             we_s, flush_s, busy_s, rv_s;
    logic [4:0]       waddr_s;
    logic [WIDTH-1:0] wdata_s, rpc_s;

    logic int_req_s, exc_req_s, eret_req_s;

    assign int_req_s  = inst_valid & status_in[0] & ~status_in[1] & (|(int_pending & status_in[15:8]));
    assign exc_req_s  = inst_valid & exc_valid;
    assign eret_req_s = inst_valid & eret_valid;

    // Next state and capture values; requests are only looked at from IDLE.
    always_comb begin
        state_s    = state_r;
        code_s     = code_r;
        bd_s       = bd_r;
        epc_s      = epc_r;
        badv_s     = badv_r;
        ip_s       = ip_r;
        stat_s     = stat_r;
        target_s   = target_r;
        has_badv_s = has_badv_r;
        eret_s     = eret_r;
        case (state_r)
            S_IDLE: begin
                if (int_req_s || exc_req_s) begin
                    code_s     = int_req_s ? 5'd0 : exc_code;
                    bd_s       = inst_bd;
                    epc_s      = inst_bd ? (inst_pc - WIDTH'(32'd4)) : inst_pc;
                    badv_s     = exc_badvaddr;
                    has_badv_s = ~int_req_s & exc_has_badv;
                    ip_s       = int_pending;
                    stat_s     = status_in;
                    eret_s     = 1'b0;
                    state_s    = (~int_req_s & exc_has_badv) ? S_W_BADV : S_W_CAUSE;
                end else if (eret_req_s) begin
                    stat_s   = status_in;
                    target_s = epc_in;
                    eret_s   = 1'b1;
                    state_s  = S_E_STATUS;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_W_BADV:   state_s = S_W_CAUSE;
            S_W_CAUSE:  state_s = S_W_EPC;
            S_W_EPC:    state_s = S_W_STATUS;
            S_W_STATUS: state_s = S_REDIRECT;
            S_E_STATUS: state_s = S_REDIRECT;
            S_REDIRECT: state_s = S_IDLE;
            default:    state_s = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they can be registered with it.
    always_comb begin
        we_s    = 1'b0;
        waddr_s = 5'd0;
        wdata_s = {WIDTH{1'b0}};
        rv_s    = 1'b0;
        rpc_s   = redirect_pc;
        case (state_s)
            S_W_BADV: begin
                we_s    = 1'b1;
                waddr_s = 5'd8;
                wdata_s = badv_s;
            end
            S_W_CAUSE: begin
                we_s    = 1'b1;
                waddr_s = 5'd13;
                wdata_s = cause_word(bd_s, ip_s, code_s);
            end
            S_W_EPC: begin
                we_s    = 1'b1;
                waddr_s = 5'd14;
                wdata_s = epc_s;
            end
            S_W_STATUS: begin
                we_s    = 1'b1;
                waddr_s = 5'd12;
                wdata_s = with_exl(stat_s, 1'b1);
            end
            S_E_STATUS: begin
                we_s    = 1'b1;
                waddr_s = 5'd12;
                wdata_s = with_exl(stat_s, 1'b0);
            end
            S_REDIRECT: begin
                rv_s  = 1'b1;
                rpc_s = eret_s ? target_s : EXC_VECTOR;
            end
            default: begin
                we_s = 1'b0;
            end
        endcase
        flush_s = (state_r == S_IDLE) && (state_s != S_IDLE);
        busy_s  = (state_s != S_IDLE);
    end

    // State, capture and output registers; reset aborts any sequence in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= S_IDLE;
            code_r         <= 5'd0;
            bd_r           <= 1'b0;
            epc_r          <= {WIDTH{1'b0}};
            badv_r         <= {WIDTH{1'b0}};
            ip_r           <= 8'd0;
            stat_r         <= {WIDTH{1'b0}};
            target_r       <= {WIDTH{1'b0}};
            has_badv_r     <= 1'b0;
            eret_r         <= 1'b0;
            cp0_we         <= 1'b0;
            cp0_waddr      <= 5'd0;
            cp0_wdata      <= {WIDTH{1'b0}};
            flush          <= 1'b0;
            busy           <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= {WIDTH{1'b0}};
        end else begin
            state_r        <= state_s;
            code_r         <= code_s;
            bd_r           <= bd_s;
            epc_r          <= epc_s;
            badv_r         <= badv_s;
            ip_r           <= ip_s;
            stat_r         <= stat_s;
            target_r       <= target_s;
            has_badv_r     <= has_badv_s;
            eret_r         <= eret_s;
            cp0_we         <= we_s;
            cp0_waddr      <= waddr_s;
            cp0_wdata      <= wdata_s;
            flush          <= flush_s;
            busy           <= busy_s;
            redirect_valid <= rv_s;
            redirect_pc    <= rpc_s;
        end
    end

endmodule
